// File: rtl/tmul_pkg.sv
// Shared types and defaults for the tile-multiply row path.
// Row packing is little-lane-first: lane i occupies bits [(i+1)*EW-1:i*EW].
package tmul_pkg;

    localparam int EW    = 16;
    localparam int LANES = 32;
    localparam int K_MAX = 16;

    typedef logic [LANES*EW-1:0] row_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REQ    = 3'd1,
        WAIT_B = 3'd2,
        FMA    = 3'd3,
        DONE   = 3'd4
    } seq_state_e;

    localparam logic [15:0] ONE = 16'h3C00;
    localparam logic [15:0] TWO = 16'h4000;

endpackage

// File: rtl/tmul_row_sequencer.sv
// Sequences one output row C[m][:] = c_init + sum_k A[m][k]*B[k][:] through an
// external FMA row, fetching B rows one at a time from the tile buffer.
module tmul_row_sequencer #(
    parameter int LANES   = tmul_pkg::LANES,
    parameter int EW      = tmul_pkg::EW,
    parameter int K_MAX   = tmul_pkg::K_MAX,
    parameter int FMA_LAT = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start_valid,
    output logic                       start_ready,
    input  logic [$clog2(K_MAX):0]     cfg_k,
    input  logic [K_MAX*EW-1:0]        a_row,
    input  logic [LANES*EW-1:0]        c_init,
    output logic                       b_req_valid,
    output logic [$clog2(K_MAX)-1:0]   b_req_idx,
    input  logic                       b_req_ready,
    input  logic                       b_rsp_valid,
    input  logic [LANES*EW-1:0]        b_rsp_data,
    output logic [EW-1:0]              fma_a,
    output logic [LANES*EW-1:0]        fma_b,
    output logic [LANES*EW-1:0]        fma_c,
    input  logic [LANES*EW-1:0]        fma_product,
    output logic                       res_valid,
    output logic [LANES*EW-1:0]        res_data,
    input  logic                       res_ready,
    output logic                       busy
);
    import tmul_pkg::*;

    localparam int KW  = $clog2(K_MAX) + 1;
    localparam int IW  = $clog2(K_MAX);
    localparam int RW  = LANES * EW;
    localparam int LCW = (FMA_LAT > 0) ? $clog2(FMA_LAT + 1) : 1;

    seq_state_e                   state, state_nx;
    logic [IW-1:0]                k;
    logic [IW-1:0]                k_last;
    logic [K_MAX-1:0][EW-1:0]     a_r;
    logic [RW-1:0]                acc;
    logic [LCW-1:0]               lat_cnt;
    logic [KW-1:0]                cfg_sat;
    logic                         lat_last;

    assign cfg_sat  = (cfg_k > KW'(K_MAX)) ? KW'(K_MAX) : cfg_k;
    assign lat_last = (lat_cnt == LCW'(FMA_LAT));

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start_valid) state_nx = (cfg_sat == '0) ? DONE : REQ;
            REQ:     if (b_req_ready) state_nx = WAIT_B;
            WAIT_B:  if (b_rsp_valid) state_nx = FMA;
            FMA:     if (lat_last)    state_nx = (k == k_last) ? DONE : REQ;
            DONE:    if (res_ready)   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Operands are frozen from capture until the product is taken, so a
    // pipelined FMA row sees stable inputs for its whole latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            k       <= '0;
            k_last  <= '0;
            a_r     <= '0;
            acc     <= '0;
            fma_a   <= '0;
            fma_b   <= '0;
            fma_c   <= '0;
            lat_cnt <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (start_valid) begin
                        a_r    <= a_row;
                        acc    <= c_init;
                        k      <= '0;
                        k_last <= IW'(cfg_sat - KW'(1));
                    end
                end
                WAIT_B: begin
                    if (b_rsp_valid) begin
                        fma_b   <= b_rsp_data;
                        fma_a   <= a_r[k];
                        fma_c   <= acc;
                        lat_cnt <= '0;
                    end
                end
                FMA: begin
                    if (lat_last) begin
                        acc <= fma_product;
                        if (k != k_last) k <= k + IW'(1);
                    end else begin
                        lat_cnt <= lat_cnt + LCW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign start_ready = (state == IDLE);
    assign busy        = (state != IDLE);
    assign b_req_valid = (state == REQ);
    assign b_req_idx   = k;
    assign res_valid   = (state == DONE);
    assign res_data    = acc;

endmodule

// File: tb/tb_tmul_row_sequencer.sv
// Directed and randomized checks of the row sequencer against a row-level
// reference (c_init plus the sum of scaled B rows), with FMA rows modelled here.
module tb_tmul_row_sequencer;
    import tmul_pkg::*;

    localparam int KW = $clog2(K_MAX) + 1;
    localparam int IW = $clog2(K_MAX);
    localparam int RW = LANES * EW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // main instance, combinational FMA row
    logic              start_valid, start_ready, b_req_valid, b_req_ready, b_rsp_valid;
    logic              res_valid, res_ready, busy;
    logic [KW-1:0]     cfg_k;
    logic [K_MAX*EW-1:0] a_row;
    row_t              c_init, b_rsp_data, fma_b, fma_c, fma_product, res_data;
    logic [IW-1:0]     b_req_idx;
    logic [EW-1:0]     fma_a;
    bit                fp_mode = 1'b1;

    // second instance, two-cycle registered FMA row
    logic              start_valid2, start_ready2, b_req_valid2, b_req_ready2, b_rsp_valid2;
    logic              res_valid2, res_ready2, busy2;
    logic [KW-1:0]     cfg_k2;
    logic [K_MAX*EW-1:0] a_row2;
    row_t              c_init2, b_rsp_data2, fma_b2, fma_c2, fma_product2, res_data2, p1, p2;
    logic [IW-1:0]     b_req_idx2;
    logic [EW-1:0]     fma_a2;

    row_t btile [K_MAX];

    tmul_row_sequencer #(.FMA_LAT(0)) u0 (
        .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(start_ready),
        .cfg_k(cfg_k), .a_row(a_row), .c_init(c_init),
        .b_req_valid(b_req_valid), .b_req_idx(b_req_idx), .b_req_ready(b_req_ready),
        .b_rsp_valid(b_rsp_valid), .b_rsp_data(b_rsp_data),
        .fma_a(fma_a), .fma_b(fma_b), .fma_c(fma_c), .fma_product(fma_product),
        .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready), .busy(busy)
    );

    tmul_row_sequencer #(.FMA_LAT(2)) u2 (
        .clk(clk), .rst_n(rst_n), .start_valid(start_valid2), .start_ready(start_ready2),
        .cfg_k(cfg_k2), .a_row(a_row2), .c_init(c_init2),
        .b_req_valid(b_req_valid2), .b_req_idx(b_req_idx2), .b_req_ready(b_req_ready2),
        .b_rsp_valid(b_rsp_valid2), .b_rsp_data(b_rsp_data2),
        .fma_a(fma_a2), .fma_b(fma_b2), .fma_c(fma_c2), .fma_product(fma_product2),
        .res_valid(res_valid2), .res_data(res_data2), .res_ready(res_ready2), .busy(busy2)
    );

    // FP16 <-> real, exact for the small values used in directed cases
    function automatic real h2r(input logic [15:0] h);
        real m;
        int  e;
        e = int'(h[14:10]);
        m = real'(h[9:0]) / 1024.0;
        if (e == 0) e = -14;
        else begin m = m + 1.0; e = e - 15; end
        while (e > 0) begin m = m * 2.0; e--; end
        while (e < 0) begin m = m / 2.0; e++; end
        return h[15] ? -m : m;
    endfunction

    function automatic logic [15:0] r2h(input real x);
        logic s;
        int   e, m;
        real  v;
        if (x == 0.0) return 16'h0000;
        s = (x < 0.0);
        v = s ? -x : x;
        e = 15;
        while (v >= 2.0) begin v = v / 2.0; e++; end
        while (v < 1.0 && e > 1) begin v = v * 2.0; e--; end
        if (v < 1.0) begin e = 0; m = $rtoi(v * 1024.0 + 0.5); end
        else m = $rtoi((v - 1.0) * 1024.0 + 0.5);
        if (m == 1024) begin m = 0; e++; end
        return {s, e[4:0], m[9:0]};
    endfunction

    function automatic row_t fma_row(input logic [15:0] a, input row_t b, input row_t c, input bit fp);
        row_t r;
        for (int l = 0; l < LANES; l++)
            r[l*EW +: EW] = fp ? r2h(h2r(a) * h2r(b[l*EW +: EW]) + h2r(c[l*EW +: EW]))
                               : 16'(a * b[l*EW +: EW] + c[l*EW +: EW]);
        return r;
    endfunction

    // Row result from the defining sum; integer lanes wrap modulo 2^16
    function automatic row_t ref_int(input int cfg, input logic [K_MAX*EW-1:0] a, input row_t c);
        row_t        r;
        int          n;
        int unsigned s;
        n = (cfg > K_MAX) ? K_MAX : cfg;
        for (int l = 0; l < LANES; l++) begin
            s = c[l*EW +: EW];
            for (int j = 0; j < n; j++) s += a[j*EW +: EW] * btile[j][l*EW +: EW];
            r[l*EW +: EW] = s[15:0];
        end
        return r;
    endfunction

    assign fma_product = fma_row(fma_a, fma_b, fma_c, fp_mode);

    always @(posedge clk) begin
        p1 <= fma_row(fma_a2, fma_b2, fma_c2, 1'b1);
        p2 <= p1;
    end
    assign fma_product2 = p2;

    task automatic chk(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // B tile buffer for u0: programmable accept stall and response delay
    int            req_stall = 0, rsp_delay = 0, req_wait = 0, rsp_wait = 0, req_seen = 0;
    bit            rsp_pend = 0, held = 0, spurious = 0;
    logic [IW-1:0] rsp_idx, held_idx;
    int            idx_q[$];

    initial begin
        b_req_ready = 1'b0; b_rsp_valid = 1'b0; b_rsp_data = '0;
        forever begin
            @(negedge clk);
            b_req_ready = 1'b0;
            b_rsp_valid = 1'b0;
            if (rsp_pend) begin
                if (rsp_wait == 0) begin
                    b_rsp_valid = 1'b1; b_rsp_data = btile[rsp_idx]; rsp_pend = 0;
                end else rsp_wait--;
            end else if (b_req_valid) begin
                req_seen++;
                if (held) chk("req_idx_stable", RW'(b_req_idx), RW'(held_idx));
                held = 1; held_idx = b_req_idx;
                if (req_wait >= req_stall) begin
                    b_req_ready = 1'b1; idx_q.push_back(int'(b_req_idx));
                    rsp_pend = 1; rsp_idx = b_req_idx; rsp_wait = rsp_delay;
                    req_wait = 0; held = 0;
                end else req_wait++;
            end
            // junk responses while the sequencer is not waiting for B must be ignored
            if (spurious && !rsp_pend && !b_rsp_valid && $urandom_range(0, 2) == 0) begin
                b_rsp_valid = 1'b1;
                b_rsp_data  = {LANES{16'($urandom)}};
            end
        end
    end

    // B tile buffer for u2: always ready, response in the next cycle
    bit            pend2 = 0;
    logic [IW-1:0] idx2 = '0;
    initial begin
        b_req_ready2 = 1'b1; b_rsp_valid2 = 1'b0; b_rsp_data2 = '0;
        forever begin
            @(negedge clk);
            b_rsp_valid2 = pend2;
            b_rsp_data2  = pend2 ? btile[idx2] : '0;
            pend2 = b_req_valid2;
            idx2  = b_req_idx2;
        end
    end

    // exp_lat: posedges after the handshake edge before res_valid is seen; <0 skips
    task automatic run_job(input string tag, input int cfg, input logic [K_MAX*EW-1:0] a, input row_t c,
                           input int rstall, input int rdelay, input int hold, input int exp_lat,
                           input row_t exp_row);
        int   cyc, n;
        row_t first;
        n = (cfg > K_MAX) ? K_MAX : cfg;
        req_stall = rstall; rsp_delay = rdelay; req_wait = 0; held = 0;
        idx_q.delete(); req_seen = 0;
        chk({tag, "_start_ready"}, RW'(start_ready), RW'(1));
        cfg_k = KW'(cfg); a_row = a; c_init = c; start_valid = 1'b1;
        @(posedge clk); #1;
        start_valid = 1'b0;
        cyc = 0;
        while (res_valid !== 1'b1 && cyc < 4000) begin
            chk({tag, "_busy"}, RW'({start_ready, busy}), RW'(2'b01));
            @(posedge clk); #1;
            cyc++;
        end
        chk({tag, "_res_valid"}, RW'(res_valid), RW'(1));
        if (exp_lat >= 0) chk({tag, "_latency"}, RW'(cyc), RW'(exp_lat));
        chk({tag, "_res_data"}, res_data, exp_row);
        chk({tag, "_req_count"}, RW'(idx_q.size()), RW'(n));
        for (int i = 0; i < n && i < idx_q.size(); i++) chk({tag, "_req_idx"}, RW'(idx_q[i]), RW'(i));
        if (n == 0) chk({tag, "_no_req"}, RW'(req_seen), RW'(0));
        first = res_data;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk({tag, "_hold_data"}, res_data, first);
            chk({tag, "_hold_ctl"}, RW'({res_valid, start_ready}), RW'(2'b10));
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        chk({tag, "_after_hs"}, RW'({res_valid, busy, start_ready}), RW'(3'b001));
    endtask

    initial begin : main
        logic [K_MAX*EW-1:0] a;
        row_t c, exp_row, c_step1;
        int   cyc, cfg, rs, rd, hd, n;

        start_valid = 0; res_ready = 0; cfg_k = '0; a_row = '0; c_init = '0;
        start_valid2 = 0; res_ready2 = 0; cfg_k2 = '0; a_row2 = '0; c_init2 = '0;
        for (int i = 0; i < K_MAX; i++) btile[i] = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_ctl", RW'({b_req_valid, res_valid, busy}), RW'(0));
        chk("reset_fma_a", RW'(fma_a), RW'(0));
        chk("reset_fma_b", fma_b, '0);
        chk("reset_fma_c", fma_c, '0);
        chk("reset_res_data", res_data, '0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("reset_start_ready", RW'(start_ready), RW'(1));

        // 4 steps of 1.0*1.0 on a zero row -> 4.0 in every lane
        fp_mode = 1;
        a = {K_MAX{ONE}};
        for (int i = 0; i < K_MAX; i++) btile[i] = {LANES{ONE}};
        run_job("basic", 4, a, '0, 0, 0, 0, 12, {LANES{16'h4400}});

        // 1.0 + 2.0*2.0 -> 5.0
        a = {K_MAX{TWO}};
        btile[0] = {LANES{TWO}};
        run_job("single", 1, a, {LANES{ONE}}, 0, 0, 0, 3, {LANES{16'h4500}});

        // zero steps: result is c_init, already up right after the handshake edge
        for (int l = 0; l < LANES; l++) c[l*EW +: EW] = 16'h1234 + 16'(l);
        run_job("k0", 0, a, c, 0, 0, 0, 0, c);

        // stalled request / response / result
        a = {K_MAX{ONE}};
        for (int i = 0; i < K_MAX; i++) btile[i] = {LANES{ONE}};
        run_job("stall", 4, a, '0, 5, 3, 10, -1, {LANES{16'h4400}});

        // randomized integer jobs, including cfg_k above K_MAX
        fp_mode = 0;
        spurious = 1;
        for (int t = 0; t < 8; t++) begin
            cfg = (t == 0) ? 20 : int'($urandom_range(0, 19));
            rs  = int'($urandom_range(0, 3));
            rd  = int'($urandom_range(0, 3));
            hd  = int'($urandom_range(0, 4));
            for (int j = 0; j < K_MAX; j++) a[j*EW +: EW] = 16'($urandom);
            for (int l = 0; l < LANES; l++) c[l*EW +: EW] = 16'($urandom);
            for (int j = 0; j < K_MAX; j++)
                for (int l = 0; l < LANES; l++) btile[j][l*EW +: EW] = 16'($urandom);
            n = (cfg > K_MAX) ? K_MAX : cfg;
            exp_row = ref_int(cfg, a, c);
            run_job("rand", cfg, a, c, rs, rd, hd, (rs == 0 && rd == 0) ? 3 * n : -1, exp_row);
        end
        spurious = 0;

        // reset while waiting for the second B row; the late response must be dropped
        fp_mode = 1;
        a = {K_MAX{ONE}};
        for (int i = 0; i < K_MAX; i++) btile[i] = {LANES{ONE}};
        req_stall = 0; rsp_delay = 6; req_wait = 0; held = 0; idx_q.delete();
        cfg_k = KW'(4); a_row = a; c_init = '0; start_valid = 1'b1;
        @(posedge clk); #1;
        start_valid = 1'b0;
        cyc = 0;
        while (idx_q.size() < 2 && cyc < 100) begin @(posedge clk); #1; cyc++; end
        chk("midrst_reached", RW'(idx_q.size()), RW'(2));
        rst_n = 1'b0;
        #1;
        chk("midrst_ctl", RW'({b_req_valid, res_valid, busy}), RW'(0));
        chk("midrst_fma_a", RW'(fma_a), RW'(0));
        chk("midrst_fma_b", fma_b, '0);
        chk("midrst_fma_c", fma_c, '0);
        chk("midrst_res_data", res_data, '0);
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("midrst_idle", RW'({busy, res_valid, b_req_valid, start_ready}), RW'(4'b0001));
        end
        run_job("after_rst", 4, a, '0, 0, 0, 0, 12, {LANES{16'h4400}});

        // FMA_LAT = 2: operands held 3 cycles per step; 1.0 + 2.0*1.0 + 1.0*2.0 -> 5.0
        a = '0;
        a[0 +: EW] = TWO;
        a[EW +: EW] = ONE;
        btile[0] = {LANES{ONE}};
        btile[1] = {LANES{TWO}};
        c_step1 = {LANES{16'h4200}};
        cfg_k2 = KW'(2); a_row2 = a; c_init2 = {LANES{ONE}}; start_valid2 = 1'b1;
        @(posedge clk); #1;
        start_valid2 = 1'b0;
        cyc = 0;
        while (res_valid2 !== 1'b1 && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
            for (int s = 0; s < 2; s++)
                if (cyc >= 5 * s + 2 && cyc <= 5 * s + 4) begin
                    chk("lat2_fma_a", RW'(fma_a2), RW'(a[s*EW +: EW]));
                    chk("lat2_fma_b", fma_b2, btile[s]);
                    chk("lat2_fma_c", fma_c2, (s == 0) ? {LANES{ONE}} : c_step1);
                end
        end
        chk("lat2_latency", RW'(cyc), RW'(10));
        chk("lat2_res_data", res_data2, {LANES{16'h4500}});
        res_ready2 = 1'b1;
        @(posedge clk); #1;
        res_ready2 = 1'b0;
        chk("lat2_after_hs", RW'({res_valid2, busy2, start_ready2}), RW'(3'b001));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
